mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk, resetn.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous reset, active low
- req0 / req1  in  1  access request; port 0 is the processor, port 1 is the loader
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  9  word address; [8:7] selects the target
- wdata0 / wdata1  in  9  write data
- gnt0 / gnt1  out  1  one-cycle grant pulse
- rvalid0 / rvalid1  out  1  one-cycle read-data-valid pulse
- rdata  out  9  read data, shared; meaningful only while rvalid0 or rvalid1 is high
- err  out  1  one-cycle pulse on an unmapped access
- ram_addr  out  7  synchronous RAM address
- ram_data  out  9  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  9  RAM read data, valid one cycle after the address edge
- leds  out  9  LED register
- busy  out  1  high whenever the state is not IDLE

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS and RDWAIT.
REQ-004 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-005 In IDLE with at least one request, the FSM SHALL go to ACCESS on the next edge and latch the owner, we, addr and wdata of the winner on that edge.
REQ-006 If both requests are high, the FSM SHALL grant the port that is not last_owner; last_owner SHALL update to the winner on that grant.
REQ-007 In ACCESS, the FSM SHALL assert gnt of the latched owner only, for exactly one cycle.
REQ-008 From ACCESS, the next state SHALL be RDWAIT for a read and IDLE for a write.
REQ-009 In RDWAIT, the FSM SHALL assert rvalid of the owner for one cycle, drive rdata, then go to IDLE.
REQ-010 Address decode SHALL use the latched addr[8:7]:
- 00 = RAM
- 01 = LED register
- 1x = unmapped
REQ-011 ram_addr SHALL be latched addr[6:0] and ram_data SHALL be latched wdata; ram_wren SHALL be high only in ACCESS with a latched write to RAM.
REQ-012 A write to the LED register SHALL load leds with latched wdata on the edge that ends ACCESS.
REQ-013 rdata in RDWAIT SHALL be:
- ram_q for a RAM read
- leds for an LED read
- 9'h000 for an unmapped read
REQ-014 An unmapped access SHALL pulse err in ACCESS for a write and in RDWAIT for a read, alongside rvalid; an unmapped write SHALL change no state outside the FSM.
REQ-015 Latency, with req sampled high in IDLE at cycle n:
- gnt at n+1
- RAM/LED write takes effect at the end of n+1
- rvalid and rdata at n+2
REQ-016 Peak throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-017 Requesters SHALL hold req, we, addr and wdata until gnt, then drop req in the cycle after gnt.
REQ-018 A req still high in a later IDLE cycle SHALL start a new transaction.
REQ-019 Request changes while in ACCESS or RDWAIT SHALL be ignored, and a started transaction SHALL always complete.
REQ-020 A request on the losing port SHALL stay pending without loss and be granted in the next IDLE cycle in which it is still high.
REQ-021 All outputs except ram_addr, ram_data and busy SHALL be registered or decoded only from state and latched fields; no input-to-output combinational path SHALL exist except ram_q to rdata in RDWAIT.

Reset
REQ-022 With resetn low at a rising edge, the block SHALL set:
- state = IDLE
- last_owner = 1, so port 0 wins the first tie
- latched addr, wdata and we = 0
- leds = 9'h000
REQ-023 The outputs SHALL read gnt0/1 = 0, rvalid0/1 = 0, err = 0, ram_wren = 0, busy = 0 and rdata = 9'h000 one cycle after reset.
REQ-024 Reset in ACCESS or RDWAIT SHALL abort the transaction without issuing gnt, rvalid or a write on that edge.
REQ-025 A request present in the first cycle after resetn rises SHALL be arbitrated normally.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Single write then read: port 0 writes 9'h1A5 to addr 9'h005; ram_wren high one cycle with ram_addr 7'h05; port 0 reads 9'h005; rvalid0 with rdata 9'h1A5 two cycles after req sampled.
- Tie after reset: req0 and req1 high together; gnt0 first; with both held, gnt1 is the next grant, then gnt0 alternates.
- LED path: port 1 writes 9'h0F3 to addr 9'h080; leds = 9'h0F3 after the ACCESS edge, RAM unchanged; a read of 9'h080 returns 9'h0F3.
- Unmapped: write to 9'h100 pulses err with no ram_wren and no leds change; a read of 9'h1FF gives rvalid with rdata 9'h000 and err high.
- Withdrawal and starvation: req1 drops during ACCESS of port-1 read; rvalid1 still fires; req0 held through a port-1 transaction is granted in the next IDLE.
- Reset mid-read: resetn low in ACCESS; no rvalid; all outputs at reset values; a fresh request after reset completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Purpose: requester-side bus of the two-port memory arbiter (processor port 0, loader port 1).
// Latency: gnt one cycle after req is sampled in IDLE; rvalid/rdata one cycle after gnt for reads.
// Backpressure: requesters hold req/we/addr/wdata until their gnt pulse, then drop req.
interface mem_arbiter_if;
    // Requester -> arbiter
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [8:0] addr0;
    logic [8:0] addr1;
    logic [8:0] wdata0;
    logic [8:0] wdata1;
    // Arbiter -> requesters
    logic       gnt0;
    logic       gnt1;
    logic       rvalid0;
    logic       rvalid1;
    logic [8:0] rdata;
    logic       err;

    // Requester side drives requests and observes grants/responses
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err
    );

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one sync RAM (addr[8:7]=00) and an LED register (01) between two ports.
// Latency: gnt at n+1, write lands at end of n+1, rvalid/rdata at n+2 (req sampled in IDLE at n).
// Backpressure: a losing or late request simply stays pending until the next IDLE cycle; no queueing.
module mem_arbiter (
    input  logic         clk,
    input  logic         resetn,
    mem_arbiter_if.slave bus,
    output logic [6:0]   ram_addr,
    output logic [8:0]   ram_data,
    output logic         ram_wren,
    input  logic [8:0]   ram_q,
    output logic [8:0]   leds,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Transaction fields captured on the edge that leaves IDLE
    logic       owner;
    logic       last_owner;
    logic       lat_we;
    logic [8:0] lat_addr;
    logic [8:0] lat_wdata;

    // Arbitration result for the current IDLE cycle
    logic       any_req;
    logic       winner;

    // Target decode from the latched address
    logic       tgt_ram;
    logic       tgt_led;
    logic       tgt_unmapped;

    // Internal copies of the requester-side outputs
    logic       gnt0_c;
    logic       gnt1_c;
    logic       rvalid0_c;
    logic       rvalid1_c;
    logic [8:0] rdata_c;
    logic       err_c;
    logic       ram_wren_c;

    // Pick the winner: a tie goes to the port that did not win last time
    always_comb begin
        any_req = bus.req0 | bus.req1;
        winner  = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = ~last_owner;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
    end

    // Decode the target of the latched transaction
    always_comb begin
        tgt_ram      = (lat_addr[8:7] == 2'b00);
        tgt_led      = (lat_addr[8:7] == 2'b01);
        tgt_unmapped = lat_addr[8];
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = lat_we ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winner's request and update round-robin history on grant
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= 9'h000;
            lat_wdata  <= 9'h000;
        end else if (state == IDLE && any_req) begin
            owner      <= winner;
            last_owner <= winner;
            lat_we     <= winner ? bus.we1    : bus.we0;
            lat_addr   <= winner ? bus.addr1  : bus.addr0;
            lat_wdata  <= winner ? bus.wdata1 : bus.wdata0;
        end
    end

    // LED register loads on the edge that ends a write ACCESS to it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            leds <= 9'h000;
        end else if (state == ACCESS && lat_we && tgt_led) begin
            leds <= lat_wdata;
        end
    end

    // Output decode from state and latched fields only. Pulses are qualified
    // by resetn so that a reset landing mid-transaction never issues a grant,
    // a response or a RAM write on that edge.
    always_comb begin
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        rvalid0_c  = 1'b0;
        rvalid1_c  = 1'b0;
        rdata_c    = 9'h000;
        err_c      = 1'b0;
        ram_wren_c = 1'b0;
        case (state)
            ACCESS: begin
                gnt0_c     = resetn & ~owner;
                gnt1_c     = resetn &  owner;
                ram_wren_c = resetn & lat_we & tgt_ram;
                err_c      = resetn & lat_we & tgt_unmapped;
            end
            RDWAIT: begin
                rvalid0_c = resetn & ~owner;
                rvalid1_c = resetn &  owner;
                err_c     = resetn & tgt_unmapped;
                if (resetn) begin
                    if (tgt_ram) begin
                        rdata_c = ram_q;
                    end else if (tgt_led) begin
                        rdata_c = leds;
                    end else begin
                        rdata_c = 9'h000;
                    end
                end
            end
            default: begin
                rdata_c = 9'h000;
            end
        endcase
    end

    assign bus.gnt0    = gnt0_c;
    assign bus.gnt1    = gnt1_c;
    assign bus.rvalid0 = rvalid0_c;
    assign bus.rvalid1 = rvalid1_c;
    assign bus.rdata   = rdata_c;
    assign bus.err     = err_c;

    // RAM port follows the latched fields; only the write enable is qualified
    assign ram_addr = lat_addr[6:0];
    assign ram_data = lat_wdata;
    assign ram_wren = ram_wren_c;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed scoreboard bench for mem_arbiter with a behavioural sync RAM.
// Latency: read responses are checked against the cycle they are due in (n+2) where uncontended.
// Backpressure: requests are held until gnt and dropped in the following cycle.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] ram_addr;
    logic [8:0] ram_data;
    logic       ram_wren;
    logic [8:0] ram_q;
    logic [8:0] leds;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .leds     (leds),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous RAM: q is the word at the address of the previous edge
    logic [8:0] mem [0:127];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 9'h000;
        ram_q = 9'h000;
    end
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // Scoreboard of expected read responses
    typedef struct {
        bit         port;
        logic [8:0] data;
        bit         err;
        int         cyc;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    rd_exp_t mon_e;

    always @(negedge clk) begin
        if (bus.rvalid0 || bus.rvalid1) begin
            tests++;
            if (bus.rvalid0 && bus.rvalid1) begin
                fails++;
                $display("FAIL rd_both_valid: rvalid0=%0b rvalid1=%0b, required one-hot", bus.rvalid0, bus.rvalid1);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: rvalid0=%0b rvalid1=%0b rdata=%h at cycle %0d, required no response",
                         bus.rvalid0, bus.rvalid1, bus.rdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rvalid1 !== mon_e.port || bus.rdata !== mon_e.data || bus.err !== mon_e.err ||
                    (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    fails++;
                    $display("FAIL rd_resp: got port=%0b data=%h err=%0b cycle=%0d, required port=%0b data=%h err=%0b cycle=%0d",
                             bus.rvalid1, bus.rdata, bus.err, cyc, mon_e.port, mon_e.data, mon_e.err, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input bit p, input bit w, input logic [8:0] a, input logic [8:0] d);
        if (p) begin
            bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic push_rd(input bit p, input logic [8:0] data, input bit e, input int c);
        rd_exp_t x;
        x.port = p; x.data = data; x.err = e; x.cyc = c;
        exp_q.push_back(x);
    endtask

    // Drive a request just after an edge; reads queue their expected response
    task automatic start_req(input bit p, input bit w, input logic [8:0] a, input logic [8:0] d,
                             input logic [8:0] exp_d, input bit exp_err, input bit chk_lat);
        @(posedge clk); #1;
        set_req(p, w, a, d);
        if (!w) push_rd(p, exp_d, exp_err, chk_lat ? cyc + 2 : -1);
    endtask

    task automatic wait_gnt(input bit p, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? bus.gnt1 : bus.gnt0) && n < 20);
        tests++;
        if ((p ? bus.gnt1 : bus.gnt0) !== 1'b1) begin
            fails++;
            $display("FAIL gnt_timeout: port %0b got no grant within %0d cycles, required a grant", p, n);
        end
    endtask

    task automatic drop_req(input bit p);
        @(posedge clk); #1;
        if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    endtask

    task automatic idle_wait(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, ram_wren, busy} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: gnt0,gnt1,rv0,rv1,err,wren,busy=%b, required 0000000",
                     {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, ram_wren, busy});
        end
        tests++;
        if (bus.rdata !== 9'h000) begin
            fails++; $display("FAIL reset_rdata: got %h, required 000", bus.rdata);
        end
        tests++;
        if (leds !== 9'h000) begin
            fails++; $display("FAIL reset_leds: got %h, required 000", leds);
        end
    endtask

    task automatic test_write_read();
        int n;
        start_req(1'b0, 1'b1, 9'h005, 9'h1A5, 9'h000, 1'b0, 1'b0);
        wait_gnt(1'b0, n);
        tests++;
        if (n != 2) begin fails++; $display("FAIL wr_gnt_latency: got %0d, required 2", n); end
        tests++;
        if (ram_wren !== 1'b1 || ram_addr !== 7'h05 || ram_data !== 9'h1A5) begin
            fails++;
            $display("FAIL wr_ram_port: wren=%b addr=%h data=%h, required 1 05 1a5", ram_wren, ram_addr, ram_data);
        end
        tests++;
        if (bus.gnt1 !== 1'b0 || bus.err !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL wr_access_flags: gnt1=%b err=%b busy=%b, required 0 0 1", bus.gnt1, bus.err, busy);
        end
        drop_req(1'b0);
        @(negedge clk);
        tests++;
        if (ram_wren !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL wr_pulse_end: wren=%b busy=%b, required 0 0", ram_wren, busy);
        end
        tests++;
        if (mem[5] !== 9'h1A5) begin fails++; $display("FAIL wr_ram_content: got %h, required 1a5", mem[5]); end

        start_req(1'b0, 1'b0, 9'h005, 9'h000, 9'h1A5, 1'b0, 1'b1);
        wait_gnt(1'b0, n);
        tests++;
        if (n != 2 || ram_wren !== 1'b0) begin
            fails++; $display("FAIL rd_gnt: latency=%0d wren=%b, required 2 0", n, ram_wren);
        end
        drop_req(1'b0);
        idle_wait(2);
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL rd_missing: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_tie();
        int g[4];
        int k = 0;
        apply_reset();
        set_req(1'b0, 1'b1, 9'h010, 9'h011);
        set_req(1'b1, 1'b1, 9'h011, 9'h022);
        for (int i = 0; i < 20 && k < 4; i++) begin
            @(negedge clk);
            if (bus.gnt0 && bus.gnt1) begin
                tests++; fails++;
                $display("FAIL tie_both_gnt: gnt0=1 gnt1=1, required one-hot");
            end
            if (bus.gnt0) begin g[k] = 0; k++; end
            else if (bus.gnt1) begin g[k] = 1; k++; end
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tests++;
        if (k != 4) begin
            fails++; $display("FAIL tie_count: got %0d grants, required 4", k);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (g[i] != (i % 2)) begin
                    fails++; $display("FAIL tie_order[%0d]: got port %0d, required port %0d", i, g[i], i % 2);
                end
            end
        end
        idle_wait(2);
        tests++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || mem[16] !== 9'h011 || mem[17] !== 9'h022) begin
            fails++;
            $display("FAIL tie_after: gnt0=%b gnt1=%b mem10=%h mem11=%h, required 0 0 011 022",
                     bus.gnt0, bus.gnt1, mem[16], mem[17]);
        end
    endtask

    task automatic test_led();
        int n;
        logic [8:0] m0;
        m0 = mem[0];
        start_req(1'b1, 1'b1, 9'h080, 9'h0F3, 9'h000, 1'b0, 1'b0);
        wait_gnt(1'b1, n);
        tests++;
        if (ram_wren !== 1'b0 || leds !== 9'h000) begin
            fails++; $display("FAIL led_access: wren=%b leds=%h, required 0 000", ram_wren, leds);
        end
        drop_req(1'b1);
        @(negedge clk);
        tests++;
        if (leds !== 9'h0F3 || mem[0] !== m0) begin
            fails++; $display("FAIL led_write: leds=%h mem0=%h, required 0f3 %h", leds, mem[0], m0);
        end
        start_req(1'b1, 1'b0, 9'h080, 9'h000, 9'h0F3, 1'b0, 1'b1);
        wait_gnt(1'b1, n);
        drop_req(1'b1);
        idle_wait(2);
    endtask

    task automatic test_unmapped();
        int n;
        start_req(1'b0, 1'b1, 9'h100, 9'h1FF, 9'h000, 1'b0, 1'b0);
        wait_gnt(1'b0, n);
        tests++;
        if (bus.err !== 1'b1 || ram_wren !== 1'b0) begin
            fails++; $display("FAIL unm_wr_access: err=%b wren=%b, required 1 0", bus.err, ram_wren);
        end
        drop_req(1'b0);
        @(negedge clk);
        tests++;
        if (bus.err !== 1'b0 || leds !== 9'h0F3 || mem[0] !== 9'h000) begin
            fails++; $display("FAIL unm_wr_after: err=%b leds=%h mem0=%h, required 0 0f3 000", bus.err, leds, mem[0]);
        end
        start_req(1'b0, 1'b0, 9'h1FF, 9'h000, 9'h000, 1'b1, 1'b1);
        wait_gnt(1'b0, n);
        tests++;
        if (bus.err !== 1'b0) begin fails++; $display("FAIL unm_rd_access_err: got %b, required 0", bus.err); end
        drop_req(1'b0);
        idle_wait(2);
    endtask

    task automatic test_withdraw();
        int n;
        start_req(1'b1, 1'b0, 9'h005, 9'h000, 9'h1A5, 1'b0, 1'b1);
        wait_gnt(1'b1, n);
        bus.req1 = 1'b0;
        set_req(1'b0, 1'b0, 9'h005, 9'h000);
        push_rd(1'b0, 9'h1A5, 1'b0, -1);
        wait_gnt(1'b0, n);
        tests++;
        if (n != 3) begin fails++; $display("FAIL starve_gnt_latency: got %0d, required 3", n); end
        drop_req(1'b0);
        idle_wait(2);
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL withdraw_missing: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 9'h005, 9'h000);
        @(posedge clk); #1;
        resetn = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || ram_wren !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_access: gnt0=%b gnt1=%b wren=%b busy=%b, required 0 0 0 1",
                     bus.gnt0, bus.gnt1, ram_wren, busy);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        set_req(1'b1, 1'b0, 9'h005, 9'h000);
        push_rd(1'b1, 9'h1A5, 1'b0, cyc + 2);
        @(negedge clk);
        tests++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, ram_wren, busy} !== 7'b0 ||
            bus.rdata !== 9'h000 || leds !== 9'h000) begin
            fails++;
            $display("FAIL rstmid_outputs: ctrl=%b rdata=%h leds=%h, required 0000000 000 000",
                     {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, ram_wren, busy}, bus.rdata, leds);
        end
        wait_gnt(1'b1, n);
        tests++;
        if (n != 1) begin fails++; $display("FAIL rstmid_fresh_gnt: got %0d more cycles, required 1", n); end
        drop_req(1'b1);
        idle_wait(2);
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL rstmid_missing: %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        resetn     = 1'b0;
        bus.req0   = 1'b0; bus.req1   = 1'b0;
        bus.we0    = 1'b0; bus.we1    = 1'b0;
        bus.addr0  = 9'h000; bus.addr1  = 9'h000;
        bus.wdata0 = 9'h000; bus.wdata1 = 9'h000;

        test_reset();
        test_write_read();
        test_tie();
        test_led();
        test_unmapped();
        test_withdraw();
        test_reset_mid();

        idle_wait(2);
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL final_queue: %0d pending, required 0", exp_q.size()); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
